// File: rtl/pga_auto_range_pkg.sv
// rtl/pga_auto_range_pkg.sv - shared gain codes, command tag and FSM encoding for the PGA auto-ranger
package pga_auto_range_pkg;

    // PGA gain codes, lowest to highest gain
    localparam logic [2:0] GAIN_0P08X = 3'd0;
    localparam logic [2:0] GAIN_0P16X = 3'd1;
    localparam logic [2:0] GAIN_0P32X = 3'd2;
    localparam logic [2:0] GAIN_0P63X = 3'd3;
    localparam logic [2:0] GAIN_1P26X = 3'd4;
    localparam logic [2:0] GAIN_2P52X = 3'd5;
    localparam logic [2:0] GAIN_5X    = 3'd6;
    localparam logic [2:0] GAIN_10X   = 3'd7;

    // Low byte of every gain-set command sent to the PGA controller
    localparam logic [7:0] GAIN_CMD_TAG = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WINDOW = 3'd1,
        ST_DECIDE = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_SETTLE = 3'd4
    } state_t;

    // Pack both channel gains into the controller command word
    function automatic logic [15:0] gain_cmd(input logic [2:0] g1, input logic [2:0] g2);
        return {1'b0, g1, 1'b0, g2, GAIN_CMD_TAG};
    endfunction

endpackage

// File: rtl/pga_chan_stat.sv
// rtl/pga_chan_stat.sv - per-channel overflow counter, peak tracker and gain step decision
module pga_chan_stat #(
    parameter logic [7:0]  OVF_THR = 8'd4,
    parameter logic [13:0] LOW_THR = 14'd2048
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        clear_i,
    input  logic        sample_i,
    input  logic [13:0] ad_i,
    input  logic        otr_i,
    input  logic [2:0]  gain_i,
    output logic [2:0]  gain_next_o,
    output logic        changed_o
);

    logic [7:0]  ovf_q, ovf_d;
    logic [13:0] peak_q, peak_d;
    logic [13:0] mag;

    // Magnitude of the sample; -8192 has no positive twin and clips to 8191
    always_comb begin
        mag = ad_i;
        if (ad_i == 14'h2000)
            mag = 14'd8191;
        else if (ad_i[13])
            mag = ~ad_i + 14'd1;
    end

    // Window statistics: saturating overflow count and running peak
    always_comb begin
        ovf_d  = ovf_q;
        peak_d = peak_q;
        if (clear_i) begin
            ovf_d  = '0;
            peak_d = '0;
        end else if (sample_i) begin
            if (otr_i && (ovf_q != 8'hFF))
                ovf_d = ovf_q + 8'd1;
            if (mag > peak_q)
                peak_d = mag;
        end
    end

    // Statistics registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ovf_q  <= '0;
            peak_q <= '0;
        end else begin
            ovf_q  <= ovf_d;
            peak_q <= peak_d;
        end
    end

    // Step decision from the completed window: overflow wins over low level
    always_comb begin
        gain_next_o = gain_i;
        if (ovf_q >= OVF_THR) begin
            if (gain_i != 3'd0)
                gain_next_o = gain_i - 3'd1;
        end else if (peak_q < LOW_THR) begin
            if (gain_i != 3'd7)
                gain_next_o = gain_i + 3'd1;
        end
        changed_o = (gain_next_o != gain_i);
    end

endmodule

// File: rtl/pga_auto_range.sv
// rtl/pga_auto_range.sv - two-channel PGA auto-ranging controller with manual host override
module pga_auto_range
    import pga_auto_range_pkg::*;
#(
    parameter logic [7:0]  OVF_THR    = 8'd4,
    parameter logic [13:0] LOW_THR    = 14'd2048,
    parameter logic [15:0] SETTLE_CYC = 16'd64,
    parameter logic [2:0]  INIT_GAIN  = 3'b011
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        AutoEn,
    input  logic        WinStart,
    input  logic        WinEnd,
    input  logic        ADValid,
    input  logic [13:0] AD1,
    input  logic [13:0] AD2,
    input  logic        ADOtr1,
    input  logic        ADOtr2,
    input  logic        HostTrig,
    input  logic [15:0] HostCmd,
    output logic [15:0] GainCmd,
    output logic        GainTrig,
    output logic [2:0]  Gain1,
    output logic [2:0]  Gain2,
    output logic        Busy
);

    state_t      state_q, state_d;
    logic [2:0]  gain1_q, gain1_d, gain2_q, gain2_d;
    logic [15:0] cmd_q, cmd_d;
    logic        trig_q, trig_d;
    logic [15:0] settle_q, settle_d;
    logic        window_clear, sample_en;
    logic [2:0]  next1, next2;
    logic        chg1, chg2;
    logic        host_cmd_unused;

    // Only the two gain fields of the host command are meaningful
    assign host_cmd_unused = ^{HostCmd[15], HostCmd[11], HostCmd[7:0]};

    assign sample_en = (state_q == ST_WINDOW) && ADValid;

    pga_chan_stat #(.OVF_THR(OVF_THR), .LOW_THR(LOW_THR)) u_ch1 (
        .CLK(CLK), .RST(RST), .clear_i(window_clear), .sample_i(sample_en),
        .ad_i(AD1), .otr_i(ADOtr1), .gain_i(gain1_q),
        .gain_next_o(next1), .changed_o(chg1)
    );

    pga_chan_stat #(.OVF_THR(OVF_THR), .LOW_THR(LOW_THR)) u_ch2 (
        .CLK(CLK), .RST(RST), .clear_i(window_clear), .sample_i(sample_en),
        .ad_i(AD2), .otr_i(ADOtr2), .gain_i(gain2_q),
        .gain_next_o(next2), .changed_o(chg2)
    );

    // Next state; a host load pre-empts every automatic transition
    always_comb begin
        state_d      = state_q;
        gain1_d      = gain1_q;
        gain2_d      = gain2_q;
        cmd_d        = cmd_q;
        trig_d       = 1'b0;
        settle_d     = settle_q;
        window_clear = 1'b0;
        if (HostTrig) begin
            gain1_d  = HostCmd[14:12];
            gain2_d  = HostCmd[10:8];
            cmd_d    = gain_cmd(HostCmd[14:12], HostCmd[10:8]);
            trig_d   = 1'b1;
            settle_d = '0;
            state_d  = ST_SETTLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (WinStart && AutoEn) begin
                        window_clear = 1'b1;
                        state_d      = ST_WINDOW;
                    end
                end
                ST_WINDOW: begin
                    if (!AutoEn)
                        state_d = ST_IDLE;
                    else if (WinEnd)
                        state_d = ST_DECIDE;
                end
                ST_DECIDE: begin
                    if (chg1 || chg2) begin
                        gain1_d = next1;
                        gain2_d = next2;
                        cmd_d   = gain_cmd(next1, next2);
                        trig_d  = 1'b1;
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    settle_d = '0;
                    state_d  = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (({1'b0, settle_q} + 17'd1) >= {1'b0, SETTLE_CYC})
                        state_d = ST_IDLE;
                    else
                        settle_d = settle_q + 16'd1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, gain and command registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            gain1_q  <= INIT_GAIN;
            gain2_q  <= INIT_GAIN;
            cmd_q    <= gain_cmd(INIT_GAIN, INIT_GAIN);
            trig_q   <= 1'b0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            gain1_q  <= gain1_d;
            gain2_q  <= gain2_d;
            cmd_q    <= cmd_d;
            trig_q   <= trig_d;
            settle_q <= settle_d;
        end
    end

    assign GainCmd  = cmd_q;
    assign GainTrig = trig_q;
    assign Gain1    = gain1_q;
    assign Gain2    = gain2_q;
    assign Busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pga_auto_range.sv
// tb/tb_pga_auto_range.sv - self-checking bench for pga_auto_range
module tb_pga_auto_range;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        AutoEn = 1'b0, WinStart = 1'b0, WinEnd = 1'b0, ADValid = 1'b0;
    logic [13:0] AD1 = '0, AD2 = '0;
    logic        ADOtr1 = 1'b0, ADOtr2 = 1'b0, HostTrig = 1'b0;
    logic [15:0] HostCmd = '0;
    logic [15:0] GainCmd;
    logic        GainTrig, Busy;
    logic [2:0]  Gain1, Gain2;

    int n_chk = 0;
    int n_fail = 0;

    pga_auto_range dut (
        .CLK(CLK), .RST(RST), .AutoEn(AutoEn), .WinStart(WinStart), .WinEnd(WinEnd),
        .ADValid(ADValid), .AD1(AD1), .AD2(AD2), .ADOtr1(ADOtr1), .ADOtr2(ADOtr2),
        .HostTrig(HostTrig), .HostCmd(HostCmd), .GainCmd(GainCmd), .GainTrig(GainTrig),
        .Gain1(Gain1), .Gain2(Gain2), .Busy(Busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] pre;
        int          nsamp;
        logic [13:0] ad1;
        logic [13:0] ad2;
        int          o1;
        int          o2;
        logic        exp_trig;
        logic [15:0] exp_cmd;
    } vec_t;

    vec_t vecs[8];

    // Samples of the next window
    logic        q_v[$];
    logic [13:0] q_a1[$], q_a2[$];
    logic        q_o1[$], q_o2[$];

    logic [2:0] g1m = 3'd3, g2m = 3'd3;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int mag(input logic [13:0] a);
        int v;
        v = int'($signed(a));
        if (v < 0) v = -v;
        if (v > 8191) v = 8191;
        return v;
    endfunction

    function automatic logic [2:0] step(input logic [2:0] g, input int ovf, input int pk);
        if (ovf >= 4) return (g == 3'd0) ? 3'd0 : g - 3'd1;
        if (pk < 2048) return (g == 3'd7) ? 3'd7 : g + 3'd1;
        return g;
    endfunction

    function automatic logic [15:0] mk_cmd(input logic [2:0] a, input logic [2:0] b);
        return {1'b0, a, 1'b0, b, 8'h05};
    endfunction

    // Reference: statistics of the queued window and the resulting command
    task automatic predict(output logic et, output logic [15:0] ec,
                           output logic [2:0] n1, output logic [2:0] n2);
        int ov1 = 0, ov2 = 0, p1 = 0, p2 = 0;
        foreach (q_v[i]) begin
            if (q_v[i]) begin
                if (q_o1[i] && ov1 < 255) ov1++;
                if (q_o2[i] && ov2 < 255) ov2++;
                if (mag(q_a1[i]) > p1) p1 = mag(q_a1[i]);
                if (mag(q_a2[i]) > p2) p2 = mag(q_a2[i]);
            end
        end
        n1 = step(g1m, ov1, p1);
        n2 = step(g2m, ov2, p2);
        et = (n1 != g1m) || (n2 != g2m);
        ec = mk_cmd(n1, n2);
    endtask

    task automatic clear_q();
        q_v.delete(); q_a1.delete(); q_a2.delete(); q_o1.delete(); q_o2.delete();
    endtask

    // Runs the queued window from IDLE; returns what appears 2 cycles after WinEnd
    task automatic do_window(output logic gt, output logic [15:0] gc);
        int cnt, extra;
        AutoEn = 1'b1;
        WinStart = 1'b1;
        @(negedge CLK);
        WinStart = 1'b0;
        foreach (q_v[i]) begin
            ADValid = q_v[i]; AD1 = q_a1[i]; AD2 = q_a2[i];
            ADOtr1 = q_o1[i]; ADOtr2 = q_o2[i];
            WinEnd = (i == q_v.size() - 1);
            @(negedge CLK);
        end
        ADValid = 1'b0; WinEnd = 1'b0; ADOtr1 = 1'b0; ADOtr2 = 1'b0;
        chk("trig_in_decide", int'(GainTrig), 0);
        @(negedge CLK);
        gt = GainTrig;
        gc = GainCmd;
        if (gt) begin
            cnt = 0;
            extra = 0;
            for (int c = 0; c < 300; c++) begin
                @(negedge CLK);
                if (!Busy) break;
                cnt++;
                if (GainTrig) extra++;
                WinStart = (cnt == 10);
                ADValid  = (cnt == 10);
                ADOtr1   = (cnt == 10);
            end
            WinStart = 1'b0; ADValid = 1'b0; ADOtr1 = 1'b0;
            chk("settle_len", cnt, 64);
            chk("settle_extra_trig", extra, 0);
            @(negedge CLK);
            chk("winstart_in_settle_ignored", int'(Busy), 0);
        end else begin
            chk("busy_after_hold", int'(Busy), 0);
        end
    endtask

    // Manual gain load from IDLE, checked through the end of its settle time
    task automatic host_load(input logic [15:0] cmd);
        int cnt, extra;
        HostCmd = cmd;
        HostTrig = 1'b1;
        @(negedge CLK);
        HostTrig = 1'b0;
        chk("host_trig", int'(GainTrig), 1);
        chk("host_cmd", int'(GainCmd), int'(mk_cmd(cmd[14:12], cmd[10:8])));
        cnt = Busy ? 1 : 0;
        extra = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge CLK);
            if (!Busy) break;
            cnt++;
            if (GainTrig) extra++;
        end
        chk("host_busy_len", cnt, 64);
        chk("host_extra_trig", extra, 0);
        g1m = cmd[14:12];
        g2m = cmd[10:8];
    endtask

    initial begin
        logic        gt, et;
        logic [15:0] gc, ec;
        logic [2:0]  n1, n2;
        int          cnt, trigs;

        vecs[0] = '{16'h3305, 5, 14'd5000, 14'd3000, 5, 0, 1'b1, 16'h2305};
        vecs[1] = '{16'h3305, 5, 14'd1000, 14'd1000, 0, 0, 1'b1, 16'h4405};
        vecs[2] = '{16'h0005, 6, 14'd8000, 14'd8000, 6, 6, 1'b0, 16'h0005};
        vecs[3] = '{16'h3305, 4, 14'h2000, 14'd3000, 0, 0, 1'b0, 16'h3305};
        vecs[4] = '{16'h7705, 3, 14'd100,  14'd100,  0, 0, 1'b0, 16'h7705};
        vecs[5] = '{16'h3305, 5, 14'd3000, 14'd2047, 4, 3, 1'b1, 16'h2405};
        vecs[6] = '{16'h3305, 3, 14'd2048, 14'd2048, 0, 0, 1'b0, 16'h3305};
        vecs[7] = '{16'h3305, 3, 14'h3801, 14'h3800, 0, 0, 1'b1, 16'h4305};

        // Reset values
        repeat (3) @(negedge CLK);
        chk("rst_gain1", int'(Gain1), 3);
        chk("rst_gain2", int'(Gain2), 3);
        chk("rst_cmd", int'(GainCmd), 16'h3305);
        chk("rst_trig", int'(GainTrig), 0);
        chk("rst_busy", int'(Busy), 0);
        RST = 1'b1;
        @(negedge CLK);

        // Table-driven windows
        for (int v = 0; v < 8; v++) begin
            host_load(vecs[v].pre);
            clear_q();
            for (int s = 0; s < vecs[v].nsamp; s++) begin
                q_v.push_back(1'b1);
                q_a1.push_back(vecs[v].ad1);
                q_a2.push_back(vecs[v].ad2);
                q_o1.push_back(s < vecs[v].o1);
                q_o2.push_back(s < vecs[v].o2);
            end
            do_window(gt, gc);
            chk($sformatf("vec%0d_trig", v), int'(gt), int'(vecs[v].exp_trig));
            chk($sformatf("vec%0d_cmd", v), int'(gc), int'(vecs[v].exp_cmd));
            chk($sformatf("vec%0d_gain1", v), int'(Gain1), int'(vecs[v].exp_cmd[14:12]));
            chk($sformatf("vec%0d_gain2", v), int'(Gain2), int'(vecs[v].exp_cmd[10:8]));
        end
        g1m = 3'd4; g2m = 3'd3;

        // HostTrig in the WinEnd cycle of a window that would step Ch1 down
        AutoEn = 1'b1;
        WinStart = 1'b1;
        @(negedge CLK);
        WinStart = 1'b0;
        for (int s = 0; s < 5; s++) begin
            ADValid = 1'b1; AD1 = 14'd5000; AD2 = 14'd5000; ADOtr1 = 1'b1;
            if (s == 4) begin
                WinEnd = 1'b1; HostTrig = 1'b1; HostCmd = 16'h7105;
            end
            @(negedge CLK);
        end
        ADValid = 1'b0; ADOtr1 = 1'b0; WinEnd = 1'b0; HostTrig = 1'b0;
        chk("hostwin_trig", int'(GainTrig), 1);
        chk("hostwin_cmd", int'(GainCmd), 16'h7105);
        cnt = Busy ? 1 : 0;
        trigs = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge CLK);
            if (!Busy) break;
            cnt++;
            if (GainTrig) trigs++;
        end
        chk("hostwin_busy_len", cnt, 64);
        chk("hostwin_second_trig", trigs, 0);
        chk("hostwin_final_cmd", int'(GainCmd), 16'h7105);
        g1m = 3'd7; g2m = 3'd1;

        // AutoEn dropped mid-window abandons it
        WinStart = 1'b1;
        @(negedge CLK);
        WinStart = 1'b0;
        for (int s = 0; s < 5; s++) begin
            ADValid = 1'b1; AD1 = 14'd100; AD2 = 14'd100; ADOtr1 = 1'b1; ADOtr2 = 1'b1;
            @(negedge CLK);
        end
        ADValid = 1'b0; ADOtr1 = 1'b0; ADOtr2 = 1'b0; AutoEn = 1'b0;
        @(negedge CLK);
        chk("autoen_drop_busy", int'(Busy), 0);
        AutoEn = 1'b1; WinEnd = 1'b1;
        @(negedge CLK);
        WinEnd = 1'b0;
        trigs = 0;
        repeat (4) begin
            @(negedge CLK);
            if (GainTrig || Busy) trigs++;
        end
        chk("autoen_drop_no_activity", trigs, 0);
        chk("autoen_drop_cmd", int'(GainCmd), 16'h7105);

        // Reset pulsed during SETTLE
        HostCmd = 16'h5205; HostTrig = 1'b1;
        @(negedge CLK);
        HostTrig = 1'b0;
        chk("pre_rst_trig", int'(GainTrig), 1);
        repeat (10) @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("midrst_gain1", int'(Gain1), 3);
        chk("midrst_gain2", int'(Gain2), 3);
        chk("midrst_cmd", int'(GainCmd), 16'h3305);
        chk("midrst_trig", int'(GainTrig), 0);
        chk("midrst_busy", int'(Busy), 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        trigs = 0; cnt = 0;
        repeat (80) begin
            @(negedge CLK);
            if (GainTrig) trigs++;
            if (Busy) cnt++;
        end
        chk("postrst_trig", trigs, 0);
        chk("postrst_busy", cnt, 0);
        g1m = 3'd3; g2m = 3'd3;

        // Randomized windows against the reference
        for (int r = 0; r < 40; r++) begin
            int m1, m2, p1, p2, ns, val;
            int mags[5] = '{1500, 2047, 2048, 2600, 8192};
            int pct[3] = '{0, 20, 70};
            if (r % 8 == 3) host_load(16'($urandom_range(0, 65535)));
            m1 = mags[$urandom_range(0, 4)];
            m2 = mags[$urandom_range(0, 4)];
            p1 = pct[$urandom_range(0, 2)];
            p2 = pct[$urandom_range(0, 2)];
            ns = $urandom_range(1, 16);
            clear_q();
            for (int s = 0; s < ns; s++) begin
                q_v.push_back($urandom_range(0, 3) != 0);
                val = $urandom_range(0, m1);
                if ($urandom_range(0, 1) == 1) val = -val;
                if (val > 8191) val = 8191;
                q_a1.push_back(14'(val));
                val = $urandom_range(0, m2);
                if ($urandom_range(0, 1) == 1) val = -val;
                if (val > 8191) val = 8191;
                q_a2.push_back(14'(val));
                q_o1.push_back($urandom_range(0, 99) < p1);
                q_o2.push_back($urandom_range(0, 99) < p2);
            end
            predict(et, ec, n1, n2);
            do_window(gt, gc);
            chk($sformatf("rnd%0d_trig", r), int'(gt), int'(et));
            chk($sformatf("rnd%0d_cmd", r), int'(gc), int'(ec));
            g1m = n1;
            g2m = n2;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Absolute time limit so the bench always ends
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/pga_auto_range.md
PGA_AUTO_RANGE -- requirements
Module: pga_auto_range

Interface
REQ-001 Parameter OVF_THR, default 8'd4: overflow-sample count per window at or above which the channel gain steps down.
REQ-002 Parameter LOW_THR, default 14'd2048: peak magnitude strictly below which the channel gain steps up.
REQ-003 Parameter SETTLE_CYC, default 16'd64: cycles ignored after any gain change.
REQ-004 Parameter INIT_GAIN, default 3'b011: reset gain code, 0.63x.
REQ-005 CLK  in  1  system clock; reset RST, asynchronous, active-low; clock CLK.
REQ-006 RST  in  1  asynchronous active-low reset.
REQ-007 AutoEn  in  1  enables automatic ranging.
REQ-008 WinStart  in  1  1-cycle pulse that opens a measurement window.
REQ-009 WinEnd  in  1  1-cycle pulse that closes the window.
REQ-010 ADValid  in  1  AD1/AD2/ADOtr1/ADOtr2 are valid this cycle.
REQ-011 AD1, AD2  in  14 each  signed two's-complement ADC samples for Ch1 and Ch2.
REQ-012 ADOtr1, ADOtr2  in  1 each  ADC out-of-range flags for Ch1 and Ch2.
REQ-013 HostTrig  in  1  1-cycle pulse that requests a manual gain load.
REQ-014 HostCmd  in  16  manual command; Ch1 gain in [14:12], Ch2 gain in [10:8].
REQ-015 GainCmd  out  16  {1'b0,G1,1'b0,G2,8'h05}, the gain-set command toward the PGA controller.
REQ-016 GainTrig  out  1  1-cycle strobe; GainCmd is valid in the same cycle.
REQ-017 Gain1, Gain2  out  3 each  current gain codes.
REQ-018 Busy  out  1  high in every state other than IDLE.

Function
REQ-019 FSM states: IDLE, WINDOW, DECIDE, ISSUE, SETTLE.
REQ-020 IDLE->WINDOW on WinStart when AutoEn=1; WinStart in any other state shall be ignored.
REQ-021 Entry to WINDOW clears both overflow counters and both peak registers.
REQ-022 WINDOW: for each ADValid cycle, increment the per-channel overflow counter when its ADOtr is set; counters are 8-bit and saturate at 255.
REQ-023 WINDOW: track per-channel peak |AD|; |-8192| saturates to 8191.
REQ-024 WINDOW->DECIDE on WinEnd; a sample with ADValid in the WinEnd cycle shall be counted.
REQ-025 DECIDE, per channel, evaluated independently: if ovf>=OVF_THR, gain-1, saturating at 0; else if peak<LOW_THR, gain+1, saturating at 7; else hold.
REQ-026 DECIDE->ISSUE if either gain changed, else DECIDE->IDLE; DECIDE lasts 1 cycle.
REQ-027 ISSUE: update GainCmd and assert GainTrig for exactly 1 cycle, then go to SETTLE.
REQ-028 SETTLE: count SETTLE_CYC cycles, then go to IDLE; ADValid is ignored during SETTLE.
REQ-029 HostTrig in any state: on the next edge, load Gain1=HostCmd[14:12] and Gain2=HostCmd[10:8], assert GainTrig for 1 cycle with the matching GainCmd, abort any window or decision in progress, and enter SETTLE.
REQ-030 If HostTrig and an auto decision coincide, HostTrig wins; no second GainTrig is issued.
REQ-031 If AutoEn falls during WINDOW, the window is abandoned and the FSM returns to IDLE with no gain change.
REQ-032 HostTrig-to-GainTrig latency: 1 cycle. WinEnd-to-GainTrig latency: 2 cycles.
REQ-033 GainTrig pulses are never issued back-to-back; at least SETTLE_CYC cycles separate them unless a HostTrig occurs.

Reset
REQ-034 While RST=0: FSM=IDLE, Gain1=Gain2=INIT_GAIN, GainCmd=16'h3305 at the default INIT_GAIN, GainTrig=0, Busy=0, all counters and peak registers 0.
REQ-035 Reset asserted mid-window or mid-settle discards all state; no GainTrig is emitted during or after the reset.

Structure
REQ-036 The shared package holds the gain-code constants (0.08x..10x), the GainCmd tag 8'h05, and the FSM state encoding.
REQ-037 One sub-module, pga_chan_stat, instantiated twice, holds one channel's overflow counter, peak tracker and step decision.

Verification
REQ-038 Defaults; window with 5 samples carrying ADOtr1=1 and Ch2 peak 3000 -> one GainTrig 2 cycles after WinEnd, GainCmd=16'h2305.
REQ-039 Window with peaks 1000/1000 and no overflow -> GainCmd=16'h4405; a WinStart during the following 64-cycle SETTLE is ignored.
REQ-040 Gains at 0 with repeated overflow -> GainCmd stays 16'h0005 and no GainTrig is issued, since no gain changed.
REQ-041 HostTrig with HostCmd=16'h7105 in the WinEnd cycle -> single GainTrig next cycle, GainCmd=16'h7105, Busy=1 for 64 cycles.
REQ-042 AD1=-8192 with no ADOtr -> peak is treated as 8191, so Ch1 gain is held.
REQ-043 RST pulsed during SETTLE -> outputs match the REQ-034 values and no GainTrig is emitted.
